// File: rtl/corners_pkg.sv
// Shared constants for the corners frame sequencer: register map, bit positions,
// FSM states and where each coordinate sits inside corn_coords.
package corners_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_WIDTH  = 4'd2;
    localparam logic [3:0] ADDR_HEIGHT = 4'd3;
    localparam logic [3:0] ADDR_LEFT   = 4'd4;
    localparam logic [3:0] ADDR_TOP    = 4'd5;
    localparam logic [3:0] ADDR_RIGHT  = 4'd6;
    localparam logic [3:0] ADDR_BOTTOM = 4'd7;
    localparam logic [3:0] ADDR_FRAMES = 4'd8;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_SYNC_ERR = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_DIM_ERR  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        STREAM   = 3'd2,
        FLUSH    = 3'd3,
        CAPTURE  = 3'd4
    } state_t;

    localparam int LEFT_X_LSB   = 112;
    localparam int LEFT_Y_LSB   = 96;
    localparam int TOP_X_LSB    = 80;
    localparam int TOP_Y_LSB    = 64;
    localparam int RIGHT_X_LSB  = 48;
    localparam int RIGHT_Y_LSB  = 32;
    localparam int BOTTOM_X_LSB = 16;
    localparam int BOTTOM_Y_LSB = 0;

    // CPU view of one point: y in the upper half, x in the lower half
    function automatic logic [31:0] pack_point(input logic [127:0] coords,
                                               input int x_lsb, input int y_lsb);
        return {coords[y_lsb +: 16], coords[x_lsb +: 16]};
    endfunction

endpackage

// File: rtl/corners_ctrl_regs.sv
// Avalon-MM register file for corners_ctrl: control, sticky status with W1C,
// frame dimensions, captured corner points and the frame counter.
module corners_ctrl_regs
    import corners_pkg::*;
#(
    parameter logic [15:0] DEF_WIDTH  = 16'd320,
    parameter logic [15:0] DEF_HEIGHT = 16'd240
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic         irq,
    input  logic         busy,
    input  logic         set_sync_err,
    input  logic         set_dim_err,
    input  logic         capture,
    input  logic         run_clear,
    input  logic [127:0] corn_coords,
    output logic         run,
    output logic         continuous,
    output logic         irq_en,
    output logic [15:0]  width,
    output logic [15:0]  height
);

    logic        run_r, cont_r, irq_en_r, irq_r;
    logic [15:0] width_r, height_r;
    logic        done_r, sync_err_r, overrun_r, dim_err_r;
    logic [31:0] left_r, top_r, right_r, bottom_r, frames_r;
    logic [31:0] readdata_r, rd_mux_s, status_s;
    logic [4:0]  w1c_s;
    logic        wr_ctrl_s, wr_width_s, wr_height_s;
    logic        unused_wd_s;

    assign wr_ctrl_s   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_width_s  = avs_write && (avs_address == ADDR_WIDTH) && !busy;
    assign wr_height_s = avs_write && (avs_address == ADDR_HEIGHT) && !busy;
    assign w1c_s       = (avs_write && (avs_address == ADDR_STATUS)) ? avs_writedata[4:0] : 5'd0;
    assign unused_wd_s = ^avs_writedata[31:16];

    assign status_s = {27'd0, dim_err_r, overrun_r, sync_err_r, busy, done_r};

    // Control and dimension registers; a CPU write to CTRL takes precedence over the hardware run clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_r    <= 1'b0;
            cont_r   <= 1'b0;
            irq_en_r <= 1'b0;
            width_r  <= DEF_WIDTH;
            height_r <= DEF_HEIGHT;
        end else begin
            if (wr_ctrl_s) begin
                run_r    <= avs_writedata[CTRL_RUN];
                cont_r   <= avs_writedata[CTRL_CONT];
                irq_en_r <= avs_writedata[CTRL_IRQ_EN];
            end else if (run_clear) begin
                run_r <= 1'b0;
            end
            if (wr_width_s)  width_r  <= avs_writedata[15:0];
            if (wr_height_s) height_r <= avs_writedata[15:0];
        end
    end

    // Sticky status bits (hardware set beats W1C), capture results and interrupt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_r     <= 1'b0;
            sync_err_r <= 1'b0;
            overrun_r  <= 1'b0;
            dim_err_r  <= 1'b0;
            left_r     <= 32'd0;
            top_r      <= 32'd0;
            right_r    <= 32'd0;
            bottom_r   <= 32'd0;
            frames_r   <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            done_r     <= capture | (done_r & ~w1c_s[ST_DONE]);
            sync_err_r <= set_sync_err | (sync_err_r & ~w1c_s[ST_SYNC_ERR]);
            overrun_r  <= (capture & done_r) | (overrun_r & ~w1c_s[ST_OVERRUN]);
            dim_err_r  <= set_dim_err | (dim_err_r & ~w1c_s[ST_DIM_ERR]);
            if (capture) begin
                left_r   <= pack_point(corn_coords, LEFT_X_LSB, LEFT_Y_LSB);
                top_r    <= pack_point(corn_coords, TOP_X_LSB, TOP_Y_LSB);
                right_r  <= pack_point(corn_coords, RIGHT_X_LSB, RIGHT_Y_LSB);
                bottom_r <= pack_point(corn_coords, BOTTOM_X_LSB, BOTTOM_Y_LSB);
                frames_r <= frames_r + 32'd1;
            end
            irq_r <= done_r & irq_en_r;
        end
    end

    // Read data mux
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            ADDR_CTRL:   rd_mux_s = {29'd0, irq_en_r, cont_r, run_r};
            ADDR_STATUS: rd_mux_s = status_s;
            ADDR_WIDTH:  rd_mux_s = {16'd0, width_r};
            ADDR_HEIGHT: rd_mux_s = {16'd0, height_r};
            ADDR_LEFT:   rd_mux_s = left_r;
            ADDR_TOP:    rd_mux_s = top_r;
            ADDR_RIGHT:  rd_mux_s = right_r;
            ADDR_BOTTOM: rd_mux_s = bottom_r;
            ADDR_FRAMES: rd_mux_s = frames_r;
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle after the strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= avs_read ? rd_mux_s : 32'd0;
        end
    end

    assign avs_readdata = readdata_r;
    assign irq          = irq_r;
    assign run          = run_r;
    assign continuous   = cont_r;
    assign irq_en       = irq_en_r;
    assign width        = width_r;
    assign height       = height_r;

endmodule

// File: rtl/corners_ctrl.sv
// Frame sequencer for the corners datapath: gates the pixel stream per frame,
// tracks position, drains the pipeline and triggers corner capture.
module corners_ctrl
    import corners_pkg::*;
#(
    parameter int DEF_WIDTH  = 320,
    parameter int DEF_HEIGHT = 240,
    parameter int PIPE_LAT   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic         irq,
    input  logic         src_write,
    input  logic         src_pixel,
    input  logic         src_sof,
    output logic         corn_write,
    output logic         corn_pixel,
    output logic         corn_clear,
    output logic [15:0]  corn_width,
    output logic [15:0]  corn_height,
    input  logic [127:0] corn_coords
);

    localparam logic [3:0] FLUSH_LAST = 4'(PIPE_LAT - 1);

    state_t      state_r;
    logic [15:0] x_r, y_r, width_r, height_r;
    logic [3:0]  flush_cnt_r;
    logic        corn_write_r, corn_pixel_r, corn_clear_r;
    logic        run_s, cont_s, irq_en_s;
    logic [15:0] reg_width_s, reg_height_s, cur_x_s, cur_y_s;
    logic        dims_ok_s, sof_s, last_col_s, last_row_s;
    logic        busy_s, capture_s, dim_err_set_s, sync_err_set_s, run_clear_s;

    assign dims_ok_s  = (reg_width_s != 16'd0) && (reg_height_s != 16'd0);
    assign sof_s      = src_write && src_sof;
    // The sof pixel accepted in WAIT_SOF is position (0,0)
    assign cur_x_s    = (state_r == STREAM) ? x_r : 16'd0;
    assign cur_y_s    = (state_r == STREAM) ? y_r : 16'd0;
    assign last_col_s = (cur_x_s == width_r - 16'd1);
    assign last_row_s = (cur_y_s == height_r - 16'd1);

    assign busy_s         = (state_r != IDLE);
    assign capture_s      = (state_r == CAPTURE);
    assign dim_err_set_s  = (state_r == IDLE) && run_s && !dims_ok_s;
    assign sync_err_set_s = (state_r == STREAM) && run_s && sof_s;
    assign run_clear_s    = dim_err_set_s || (capture_s && !(run_s && cont_s));

    corners_ctrl_regs #(
        .DEF_WIDTH  (16'(DEF_WIDTH)),
        .DEF_HEIGHT (16'(DEF_HEIGHT))
    ) u_regs (
        .clock         (clock),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .busy          (busy_s),
        .set_sync_err  (sync_err_set_s),
        .set_dim_err   (dim_err_set_s),
        .capture       (capture_s),
        .run_clear     (run_clear_s),
        .corn_coords   (corn_coords),
        .run           (run_s),
        .continuous    (cont_s),
        .irq_en        (irq_en_s),
        .width         (reg_width_s),
        .height        (reg_height_s)
    );

    // Frame sequencer with registered datapath controls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            x_r          <= 16'd0;
            y_r          <= 16'd0;
            flush_cnt_r  <= 4'd0;
            width_r      <= 16'(DEF_WIDTH);
            height_r     <= 16'(DEF_HEIGHT);
            corn_write_r <= 1'b0;
            corn_pixel_r <= 1'b0;
            corn_clear_r <= 1'b0;
        end else begin
            corn_write_r <= 1'b0;
            corn_clear_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (run_s && dims_ok_s) begin
                        width_r      <= reg_width_s;
                        height_r     <= reg_height_s;
                        corn_clear_r <= 1'b1;
                        state_r      <= WAIT_SOF;
                    end
                end
                WAIT_SOF, STREAM: begin
                    if (!run_s) begin
                        state_r <= IDLE;
                    end else if ((state_r == STREAM) && sof_s) begin
                        corn_clear_r <= 1'b1;
                        state_r      <= WAIT_SOF;
                    end else if (src_write && ((state_r == STREAM) || src_sof)) begin
                        corn_write_r <= 1'b1;
                        corn_pixel_r <= src_pixel;
                        if (last_col_s) begin
                            x_r <= 16'd0;
                            if (last_row_s) begin
                                flush_cnt_r <= 4'd0;
                                state_r     <= FLUSH;
                            end else begin
                                y_r     <= cur_y_s + 16'd1;
                                state_r <= STREAM;
                            end
                        end else begin
                            x_r     <= cur_x_s + 16'd1;
                            y_r     <= cur_y_s;
                            state_r <= STREAM;
                        end
                    end
                end
                FLUSH: begin
                    if (!run_s) begin
                        state_r <= IDLE;
                    end else if (flush_cnt_r == FLUSH_LAST) begin
                        state_r <= CAPTURE;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + 4'd1;
                    end
                end
                CAPTURE: begin
                    if (run_s && cont_s) begin
                        corn_clear_r <= 1'b1;
                        state_r      <= WAIT_SOF;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign corn_write  = corn_write_r;
    assign corn_pixel  = corn_pixel_r;
    assign corn_clear  = corn_clear_r;
    assign corn_width  = width_r;
    assign corn_height = height_r;

endmodule

// File: tb/tb_corners_ctrl.sv
// Self-checking bench for corners_ctrl: register vector tables plus a pixel
// scoreboard that checks every forwarded pixel and its one-cycle latency.
module tb_corners_ctrl;

    localparam int PIPE_LAT = 4;
    localparam logic [127:0] COORDS_A = {16'd1, 16'd0, 16'd2, 16'd0, 16'd3, 16'd2, 16'd0, 16'd2};
    localparam logic [127:0] COORDS_B = {8{16'h00AA}};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   avs_address = 4'd0;
    logic         avs_read = 1'b0;
    logic         avs_write = 1'b0;
    logic [31:0]  avs_writedata = 32'd0;
    logic [31:0]  avs_readdata;
    logic         irq;
    logic         src_write = 1'b0;
    logic         src_pixel = 1'b0;
    logic         src_sof = 1'b0;
    logic         corn_write, corn_pixel, corn_clear;
    logic [15:0]  corn_width, corn_height;
    logic [127:0] corn_coords = COORDS_A;

    corners_ctrl #(.DEF_WIDTH(320), .DEF_HEIGHT(240), .PIPE_LAT(PIPE_LAT)) dut (
        .clock(clock), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
        .src_write(src_write), .src_pixel(src_pixel), .src_sof(src_sof),
        .corn_write(corn_write), .corn_pixel(corn_pixel), .corn_clear(corn_clear),
        .corn_width(corn_width), .corn_height(corn_height), .corn_coords(corn_coords)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0, n_clear = 0, n_fwd = 0, last_cyc = 0;

    typedef struct { logic pix; int cyc; } exp_pix_t;
    exp_pix_t exp_q[$];
    exp_pix_t mon_e;

    typedef struct { logic wr; logic [3:0] addr; logic [31:0] data; logic [31:0] exp; } reg_vec_t;
    reg_vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every corn_write must match the next expected pixel, one cycle after it was driven
    always @(negedge clock) begin
        if (!reset) begin
            if (corn_clear) n_clear++;
            if (corn_write) begin
                n_fwd++;
                if (exp_q.size() == 0) begin
                    check("unexpected_corn_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", {31'd0, corn_pixel}, {31'd0, mon_e.pix});
                    check("pixel_latency", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clock);
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clock);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic px(input logic sof, input logic pix, input logic fwd);
        src_write = 1'b1; src_sof = sof; src_pixel = pix;
        if (fwd) exp_q.push_back('{pix, cyc + 1});
        last_cyc = cyc;
        @(negedge clock);
        src_write = 1'b0; src_sof = 1'b0; src_pixel = 1'b0;
    endtask

    function automatic logic pat(input int i);
        return (i % 3) == 1;
    endfunction

    // Full frame with a two-cycle stall in the middle
    task automatic frame(input int w, input int h);
        for (int i = 0; i < w * h; i++) begin
            px(i == 0, pat(i), 1'b1);
            if (i == 5) idle(2);
        end
    endtask

    task automatic run_vecs();
        logic [31:0] rd;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].addr, vecs[i].data);
            end else begin
                cpu_read(vecs[i].addr, rd);
                check($sformatf("reg[%0d]", vecs[i].addr), rd, vecs[i].exp);
            end
        end
        vecs.delete();
    endtask

    function automatic reg_vec_t W(input logic [3:0] a, input logic [31:0] d);
        return '{1'b1, a, d, 32'd0};
    endfunction

    function automatic reg_vec_t R(input logic [3:0] a, input logic [31:0] e);
        return '{1'b0, a, 32'd0, e};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        src_write = 1'b0; src_sof = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
        corn_coords = COORDS_A;
        idle(2);
        reset = 1'b0;
        exp_q.delete();
        n_clear = 0; n_fwd = 0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_corn_write", {31'd0, corn_write}, 32'd0);
        check("reset_corn_width", {16'd0, corn_width}, 32'd320);
        check("reset_corn_height", {16'd0, corn_height}, 32'd240);
        vecs.push_back(R(4'd2, 32'd320));
        vecs.push_back(R(4'd3, 32'd240));
        vecs.push_back(R(4'd1, 32'd0));
        vecs.push_back(R(4'd0, 32'd0));
        vecs.push_back(R(4'd8, 32'd0));
        vecs.push_back(R(4'd4, 32'd0));
        vecs.push_back(W(4'd9, 32'hFFFF_FFFF));
        vecs.push_back(R(4'd9, 32'd0));
        vecs.push_back(R(4'd15, 32'd0));
        run_vecs();

        // Single-shot frame
        vecs.push_back(W(4'd2, 32'd4));
        vecs.push_back(W(4'd3, 32'd3));
        vecs.push_back(W(4'd0, 32'h5));
        run_vecs();
        idle(1);
        px(1'b0, 1'b1, 1'b0);
        check("latched_width", {16'd0, corn_width}, 32'd4);
        check("latched_height", {16'd0, corn_height}, 32'd3);
        frame(4, 3);
        for (int i = 0; i < 64 && irq !== 1'b1; i++) @(negedge clock);
        check("irq_rise", {31'd0, irq}, 32'd1);
        check("capture_latency", cyc - last_cyc, PIPE_LAT + 3);
        check("single_clears", n_clear, 32'd1);
        check("single_fwd", n_fwd, 32'd12);
        check("single_queue_empty", exp_q.size(), 32'd0);
        vecs.push_back(R(4'd4, 32'h0000_0001));
        vecs.push_back(R(4'd5, 32'h0000_0002));
        vecs.push_back(R(4'd6, 32'h0002_0003));
        vecs.push_back(R(4'd7, 32'h0002_0000));
        vecs.push_back(R(4'd1, 32'h1));
        vecs.push_back(R(4'd8, 32'd1));
        vecs.push_back(R(4'd0, 32'h4));
        run_vecs();

        // Continuous mode, done never cleared
        do_reset();
        vecs.push_back(W(4'd2, 32'd4));
        vecs.push_back(W(4'd3, 32'd3));
        vecs.push_back(W(4'd0, 32'h3));
        run_vecs();
        idle(1);
        for (int f = 0; f < 3; f++) begin
            frame(4, 3);
            idle(PIPE_LAT + 4);
        end
        cpu_write(4'd0, 32'd0);
        idle(1);
        check("cont_clears", n_clear, 32'd4);
        check("cont_fwd", n_fwd, 32'd36);
        check("cont_irq_off", {31'd0, irq}, 32'd0);
        vecs.push_back(R(4'd8, 32'd3));
        vecs.push_back(R(4'd1, 32'h9));
        run_vecs();

        // Early sof followed by a complete frame
        do_reset();
        vecs.push_back(W(4'd2, 32'd4));
        vecs.push_back(W(4'd3, 32'd3));
        vecs.push_back(W(4'd0, 32'h1));
        run_vecs();
        idle(1);
        for (int i = 0; i < 7; i++) px(i == 0, pat(i), 1'b1);
        px(1'b1, 1'b1, 1'b0);
        frame(4, 3);
        idle(PIPE_LAT + 6);
        check("sync_clears", n_clear, 32'd2);
        check("sync_fwd", n_fwd, 32'd19);
        vecs.push_back(R(4'd8, 32'd1));
        vecs.push_back(R(4'd1, 32'h5));
        vecs.push_back(R(4'd4, 32'h0000_0001));
        vecs.push_back(R(4'd0, 32'h0));
        run_vecs();

        // Abort mid-stream after one good capture
        do_reset();
        vecs.push_back(W(4'd2, 32'd4));
        vecs.push_back(W(4'd3, 32'd3));
        vecs.push_back(W(4'd0, 32'h1));
        run_vecs();
        idle(1);
        frame(4, 3);
        idle(PIPE_LAT + 6);
        corn_coords = COORDS_B;
        cpu_write(4'd0, 32'h1);
        idle(1);
        for (int i = 0; i < 5; i++) px(i == 0, pat(i), 1'b1);
        cpu_write(4'd0, 32'h0);
        px(1'b0, 1'b1, 1'b0);
        vecs.push_back(R(4'd1, 32'h1));
        run_vecs();
        for (int i = 0; i < 3; i++) px(1'b0, 1'b1, 1'b0);
        px(1'b1, 1'b1, 1'b0);
        idle(PIPE_LAT + 6);
        check("abort_fwd", n_fwd, 32'd17);
        check("abort_queue_empty", exp_q.size(), 32'd0);
        vecs.push_back(R(4'd8, 32'd1));
        vecs.push_back(R(4'd4, 32'h0000_0001));
        vecs.push_back(R(4'd6, 32'h0002_0003));
        run_vecs();

        // Dimension guard and WIDTH write while busy
        do_reset();
        vecs.push_back(W(4'd2, 32'd0));
        vecs.push_back(W(4'd0, 32'h1));
        run_vecs();
        idle(3);
        vecs.push_back(R(4'd1, 32'h10));
        vecs.push_back(R(4'd0, 32'h0));
        vecs.push_back(R(4'd2, 32'h0));
        vecs.push_back(W(4'd2, 32'd4));
        vecs.push_back(W(4'd0, 32'h1));
        run_vecs();
        idle(2);
        vecs.push_back(W(4'd2, 32'd7));
        vecs.push_back(R(4'd2, 32'd4));
        vecs.push_back(R(4'd1, 32'h12));
        vecs.push_back(W(4'd0, 32'h0));
        run_vecs();
        idle(2);
        vecs.push_back(W(4'd1, 32'h10));
        vecs.push_back(R(4'd1, 32'h0));
        run_vecs();
        check("dim_no_clear", n_clear, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/corners_ctrl.md
Name: corners_ctrl

Overview:
- Frame sequencer and Avalon-MM register front-end for the `corners` extreme-point datapath.
- Sits between the upstream binarised pixel stream and `corners`:
  - gates the pixel stream per frame;
  - clears the datapath before each frame;
  - counts pixels to detect frame end;
  - waits for the datapath pipeline to drain, then captures the four corner coordinates into CPU-readable shadow registers and raises an interrupt.

Parameters:
- DEF_WIDTH, 320, reset value of the WIDTH register.
- DEF_HEIGHT, 240, reset value of the HEIGHT register.
- PIPE_LAT, 4, number of cycles waited after the last forwarded pixel before corner outputs are sampled (range 1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  4  register word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- irq  out  1  interrupt, level.
- src_write  in  1  upstream pixel valid.
- src_pixel  in  1  upstream binary pixel.
- src_sof  in  1  start-of-frame, qualified by src_write.
- corn_write  out  1  pixel valid to datapath.
- corn_pixel  out  1  pixel to datapath.
- corn_clear  out  1  one-cycle datapath clear pulse.
- corn_width  out  16  latched frame width.
- corn_height  out  16  latched frame height.
- corn_coords  in  128  {left_x, left_y, top_x, top_y, right_x, right_y, bottom_x, bottom_y}, 16 bits each, MSB first.

Behaviour:

Reset values:
- All outputs are 0, except corn_width = DEF_WIDTH and corn_height = DEF_HEIGHT.
- All registers are 0, except WIDTH and HEIGHT.
- The FSM resets to IDLE.

Register map (word address):
- 0 CTRL, rw: b0 run, b1 continuous, b2 irq_en.
- 1 STATUS:
  - b0 done: sticky; write-1-to-clear.
  - b1 busy: read-only; set when FSM is not IDLE.
  - b2 sync_err: sticky; write-1-to-clear.
  - b3 overrun: sticky; write-1-to-clear.
  - b4 dim_err: sticky; write-1-to-clear.
- 2 WIDTH, rw, [15:0].
- 3 HEIGHT, rw, [15:0].
- 4 LEFT, ro: {y[31:16], x[15:0]}.
- 5 TOP, ro: {y[31:16], x[15:0]}.
- 6 RIGHT, ro: {y[31:16], x[15:0]}.
- 7 BOTTOM, ro: {y[31:16], x[15:0]}.
- 8 FRAMES, ro, 32-bit count of captured frames; wraps.
- Unmapped addresses read 0; writes to them are ignored.

Register access rules:
- WIDTH and HEIGHT writes are ignored while busy.
- irq = done & irq_en, registered.

FSM states and transitions:
- IDLE:
  - If run = 1 and WIDTH and HEIGHT are both nonzero: latch corn_width/corn_height, pulse corn_clear, go to WAIT_SOF.
  - If run = 1 and either dimension is 0: set dim_err, clear run, stay in IDLE.
- WAIT_SOF:
  - Pixels are dropped.
  - On src_write & src_sof: that pixel is forwarded as (x,y) = (0,0); go to STREAM.
- STREAM:
  - Each src_write is forwarded with 1-cycle latency (corn_write/corn_pixel registered).
  - x increments; at x == width-1, x wraps to 0 and y increments.
  - The pixel at (width-1, height-1) is forwarded; then go to FLUSH.
- FLUSH:
  - corn_write = 0.
  - Count PIPE_LAT cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Latch corn_coords into LEFT..BOTTOM.
  - FRAMES++.
  - If done was already set, set overrun.
  - Set done.
  - If run & continuous: pulse corn_clear, go to WAIT_SOF. Otherwise clear run, go to IDLE.

Boundary cases:
- src_sof in STREAM (short frame):
  - Set sync_err.
  - The sof pixel is dropped.
  - Pulse corn_clear; go to WAIT_SOF; no capture.
- run cleared by CPU in WAIT_SOF, STREAM or FLUSH:
  - Abort to IDLE next cycle.
  - No capture; result registers unchanged.
  - corn_write = 0.
- Simultaneous CPU W1C and hardware set of the same STATUS bit: the set wins.
- Read of STATUS during the CAPTURE cycle returns the pre-capture value.
- src_write low cycles inside STREAM stall the counters; no timeout.

Decomposition:
- corners_pkg holds:
  - register address constants;
  - CTRL/STATUS bit indices;
  - FSM state enum {IDLE, WAIT_SOF, STREAM, FLUSH, CAPTURE};
  - coordinate slice offsets within corn_coords.
- One sub-module: corners_ctrl_regs, the Avalon register file with W1C logic and readdata mux.
  - Its inputs: FSM status/set strobes and the capture strobe.
  - Its outputs: run, continuous, irq_en, WIDTH, HEIGHT, and a run-clear input.
- The FSM, counters and stream gating stay in corners_ctrl.

Test Plan:
1. Reset check: WIDTH/HEIGHT reads give 320/240, STATUS = 0, irq = 0, corn_write = 0 → all hold.
2. Single-shot frame:
   - Setup: WIDTH = 4, HEIGHT = 3, CTRL = 0x5.
   - Stimulus: 12-pixel frame with sof on the first pixel; model returns coords (1,0), (2,0), (3,2), (0,2).
   - Required response: exactly one corn_clear; 12 corn_write pulses each 1 cycle late; capture PIPE_LAT cycles after the last pixel; LEFT = 0x00000001; STATUS.done = 1; irq = 1; FRAMES = 1; run reads 0.
3. Continuous mode:
   - Stimulus: CTRL = 0x3, three back-to-back frames, done not cleared.
   - Required response: FRAMES = 3; overrun = 1; corn_clear before each frame.
4. Early sof:
   - Stimulus: sof at pixel 7 of a 12-pixel frame, followed by one full frame.
   - Required response: sync_err = 1; a clear pulse; no capture from the broken frame; next full frame captured with FRAMES = 1.
5. Abort:
   - Stimulus: write CTRL = 0 mid-STREAM.
   - Required response: busy = 0 within 2 cycles; corn_write stays 0; results and FRAMES unchanged.
6. Dimension guard:
   - Stimulus: WIDTH = 0, then CTRL = 0x1. Separately, write WIDTH while busy.
   - Required response: dim_err = 1 and FSM stays IDLE; the write while busy is ignored (readback unchanged).
